// File: rtl/mux_nx1_rr_if.sv
// Bus bundle for mux_nx1_rr: lane inputs, mode/selector controls and the registered output tags.
// The golden-compare signals ref_data/err_count exist only when MUX_CHECK_EN is defined.
interface mux_nx1_rr_if #(
  parameter int WIDTH    = 2,
  parameter int CHANNELS = 4,
  parameter int SEL_W    = 2
);
  logic                      mode;
  logic [SEL_W-1:0]          selector;
  logic [CHANNELS*WIDTH-1:0] data_in;
  logic [CHANNELS-1:0]       valid_in;
  logic [WIDTH-1:0]          data_out;
  logic                      valid_out;
  logic [SEL_W-1:0]          sel_out;
`ifdef MUX_CHECK_EN
  logic [WIDTH-1:0]          ref_data;
  logic [7:0]                err_count;
`endif

  modport master (
`ifdef MUX_CHECK_EN
    output ref_data,
    input  err_count,
`endif
    output mode, selector, data_in, valid_in,
    input  data_out, valid_out, sel_out
  );

  modport slave (
`ifdef MUX_CHECK_EN
    input  ref_data,
    output err_count,
`endif
    input  mode, selector, data_in, valid_in,
    output data_out, valid_out, sel_out
  );
endinterface

// File: rtl/mux_nx1_rr.sv
// Registered N:1 lane mux with external select or round-robin grant over valid lanes.
// Optional golden-data mismatch counter is enabled with the MUX_CHECK_EN define.
module mux_nx1_rr #(
  parameter int WIDTH    = 2,
  parameter int CHANNELS = 4,
  parameter int SEL_W    = 2
) (
  input logic           clk,
  input logic           reset_L,
  mux_nx1_rr_if.slave   bus
);

  logic [SEL_W-1:0] rr_ptr;
  logic             rr_found;
  int               rr_grant;
  int               idx;
  logic             sel_in_range;
  logic             sel_valid;

  function automatic logic [WIDTH-1:0] lane(input logic [CHANNELS*WIDTH-1:0] d, input int k);
    return WIDTH'(d >> (k * WIDTH));
  endfunction

  // Search starts at rr_ptr; rr_ptr < CHANNELS so one subtraction is enough to wrap.
  always_comb begin
    rr_found = 1'b0;
    rr_grant = 0;
    idx      = 0;
    for (int i = 0; i < CHANNELS; i++) begin
      idx = int'(rr_ptr) + i;
      if (idx >= CHANNELS) idx = idx - CHANNELS;
      if (!rr_found && |(bus.valid_in & (CHANNELS'(1) << idx))) begin
        rr_found = 1'b1;
        rr_grant = idx;
      end
    end
  end

  always_comb begin
    sel_in_range = int'(bus.selector) < CHANNELS;
    sel_valid    = |(bus.valid_in & (CHANNELS'(1) << bus.selector));
  end

  always_ff @(posedge clk or negedge reset_L) begin
    if (!reset_L) begin
      bus.data_out  <= '0;
      bus.valid_out <= 1'b0;
      bus.sel_out   <= '0;
      rr_ptr        <= '0;
    end else if (!bus.mode) begin
      bus.sel_out <= bus.selector;
      if (sel_in_range) begin
        bus.data_out  <= lane(bus.data_in, int'(bus.selector));
        bus.valid_out <= sel_valid;
      end else begin
        bus.data_out  <= '0;
        bus.valid_out <= 1'b0;
      end
    end else if (rr_found) begin
      bus.data_out  <= lane(bus.data_in, rr_grant);
      bus.valid_out <= 1'b1;
      bus.sel_out   <= SEL_W'(rr_grant);
      rr_ptr        <= (rr_grant == CHANNELS - 1) ? '0 : SEL_W'(rr_grant + 1);
    end else begin
      // Nothing to grant: data/sel keep the last grant for observability.
      bus.valid_out <= 1'b0;
    end
  end

`ifdef MUX_CHECK_EN
  always_ff @(posedge clk or negedge reset_L) begin
    if (!reset_L) begin
      bus.err_count <= '0;
    end else if (bus.valid_out && (bus.data_out != bus.ref_data) && (bus.err_count != 8'hFF)) begin
      bus.err_count <= bus.err_count + 8'd1;
    end
  end
`endif

endmodule

// File: tb/tb_mux_nx1_rr.sv
// Scoreboard bench for mux_nx1_rr: directed vectors push expected outputs, a monitor pops and compares.
// The err_count checks are compiled in only with MUX_CHECK_EN.
module tb_mux_nx1_rr;
  localparam int WIDTH    = 2;
  localparam int CHANNELS = 4;
  localparam int SEL_W    = 2;

  logic clk = 1'b0;
  logic reset_L;
  always #5 clk = ~clk;

  mux_nx1_rr_if #(.WIDTH(WIDTH), .CHANNELS(CHANNELS), .SEL_W(SEL_W)) bus ();

  mux_nx1_rr #(.WIDTH(WIDTH), .CHANNELS(CHANNELS), .SEL_W(SEL_W)) dut (
    .clk     (clk),
    .reset_L (reset_L),
    .bus     (bus)
  );

  typedef struct packed {
    logic [1:0] d;
    logic       v;
    logic [1:0] s;
    int         id;
  } exp_t;

  exp_t sb[$];
  int   checks = 0;
  int   passes = 0;
  int   vec_id = 0;

  task automatic check(input string name, input int act, input int exp);
    checks++;
    if (act == exp) passes++;
    else $display("FAIL %s: got %0d expected %0d", name, act, exp);
  endtask

  initial begin : monitor
    exp_t e;
    forever begin
      @(posedge clk);
      #1;
      if (sb.size() > 0) begin
        e = sb.pop_front();
        checks++;
        if (bus.data_out === e.d && bus.valid_out === e.v && bus.sel_out === e.s) passes++;
        else $display("FAIL vec%0d data/valid/sel: got %0d/%0d/%0d expected %0d/%0d/%0d",
                      e.id, bus.data_out, bus.valid_out, bus.sel_out, e.d, e.v, e.s);
      end
    end
  end

  task automatic step(input logic m, input logic [1:0] sel, input logic [7:0] d, input logic [3:0] v,
                      input logic [1:0] ed, input logic ev, input logic [1:0] es);
    @(negedge clk);
    bus.mode     = m;
    bus.selector = sel;
    bus.data_in  = d;
    bus.valid_in = v;
    vec_id++;
    sb.push_back('{d: ed, v: ev, s: es, id: vec_id});
  endtask

  task automatic drain();
    int n;
    n = 0;
    while (sb.size() > 0 && n < 200) begin
      #1;
      n++;
    end
    check("drain_timeout", sb.size(), 0);
  endtask

  // Async reset between edges; outputs must clear with no clock edge.
  task automatic reset_pulse(input string name);
    drain();
    #1;
    reset_L  = 1'b0;
    bus.mode = 1'b0;
    #1;
    check({name, "_data"},  int'(bus.data_out),  0);
    check({name, "_valid"}, int'(bus.valid_out), 0);
    check({name, "_sel"},   int'(bus.sel_out),   0);
`ifdef MUX_CHECK_EN
    check({name, "_err"},   int'(bus.err_count), 0);
`endif
    @(negedge clk);
    reset_L = 1'b1;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "watchdog");
  end

  initial begin
    reset_L      = 1'b0;
    bus.mode     = 1'b0;
    bus.selector = '0;
    bus.data_in  = '0;
    bus.valid_in = '0;
`ifdef MUX_CHECK_EN
    bus.ref_data = '0;
`endif
    repeat (2) @(posedge clk);
    #1;
    check("init_data",  int'(bus.data_out),  0);
    check("init_valid", int'(bus.valid_out), 0);
    check("init_sel",   int'(bus.sel_out),   0);
    @(negedge clk);
    reset_L = 1'b1;

    // External select, including pass-through of an invalid lane
    step(0, 2'd1, 8'h0C, 4'b0010, 2'd3, 1'b1, 2'd1);
    step(0, 2'd2, 8'h20, 4'b1011, 2'd2, 1'b0, 2'd2);
    reset_pulse("async_rst");

    // Round-robin from reset over all-valid lanes 0,1,2,3
    step(1, 2'd0, 8'hE4, 4'b1111, 2'd0, 1'b1, 2'd0);
    step(1, 2'd0, 8'hE4, 4'b1111, 2'd1, 1'b1, 2'd1);
    step(1, 2'd0, 8'hE4, 4'b1111, 2'd2, 1'b1, 2'd2);
    step(1, 2'd0, 8'hE4, 4'b1111, 2'd3, 1'b1, 2'd3);
    step(1, 2'd0, 8'hE4, 4'b1111, 2'd0, 1'b1, 2'd0);

    // rr_ptr=1, sparse valids, then idle hold, then resume at lane 0
    step(1, 2'd0, 8'hE4, 4'b1001, 2'd3, 1'b1, 2'd3);
    step(1, 2'd0, 8'hE4, 4'b1001, 2'd0, 1'b1, 2'd0);
    step(1, 2'd0, 8'hE4, 4'b1001, 2'd3, 1'b1, 2'd3);
    step(1, 2'd0, 8'hE4, 4'b0000, 2'd3, 1'b0, 2'd3);
    step(1, 2'd0, 8'hE4, 4'b1111, 2'd0, 1'b1, 2'd0);

    // rr_ptr survives a mode=0 period; reset returns the search to lane 0
    reset_pulse("mid_rst1");
    step(1, 2'd0, 8'hE4, 4'b1111, 2'd0, 1'b1, 2'd0);
    step(1, 2'd0, 8'hE4, 4'b1111, 2'd1, 1'b1, 2'd1);
    step(0, 2'd3, 8'hE4, 4'b1111, 2'd3, 1'b1, 2'd3);
    step(0, 2'd0, 8'hE4, 4'b0000, 2'd0, 1'b0, 2'd0);
    step(0, 2'd1, 8'hE4, 4'b0000, 2'd1, 1'b0, 2'd1);
    step(1, 2'd0, 8'hE4, 4'b1111, 2'd2, 1'b1, 2'd2);
    reset_pulse("mid_rst2");
    step(1, 2'd0, 8'hE4, 4'b1111, 2'd0, 1'b1, 2'd0);
    step(1, 2'd0, 8'hE4, 4'b1111, 2'd1, 1'b1, 2'd1);
    drain();

`ifdef MUX_CHECK_EN
    bus.selector = 2'd0;
    bus.data_in  = 8'h01;
    bus.valid_in = 4'b0001;
    bus.ref_data = 2'd1;
    reset_pulse("chk_rst");
    @(negedge clk);
    bus.ref_data = 2'd2;
    repeat (3) @(negedge clk);
    bus.ref_data = 2'd1;
    bus.valid_in = 4'b0000;
    @(negedge clk);
    bus.ref_data = 2'd2;
    repeat (2) @(negedge clk);
    check("err_count_3", int'(bus.err_count), 3);
    bus.ref_data = 2'd1;
    bus.valid_in = 4'b0001;
    @(negedge clk);
    bus.ref_data = 2'd2;
    repeat (300) @(negedge clk);
    check("err_count_sat", int'(bus.err_count), 255);
`endif

    $display("%0d/%0d checks passed", passes, checks);
    $finish;
  end
endmodule
